namuru_dump_collector: RTL and testbench

//  Parametrised N-channel accumulation-dump collector for the namuru GPS correlator, sitting between
//  the tracking_channel array and the register interface in the gps_rec_clk domain.

---
 rtl/namuru_dump_collector.sv | 119 +++++++++++
 tb/tb_namuru_dump_collector.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/namuru_dump_collector.sv
// N-channel correlator dump collector: shadow bank, new-data/overrun flags, irq, 1-cycle read port.
// Optional per-channel dump timestamps when NAMURU_DUMP_TIMESTAMP_EN is defined.
module namuru_dump_collector #(
  parameter int NUM_CHANNELS = 4,
  parameter int ACC_WIDTH    = 16
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                accum_int,
  input  logic [NUM_CHANNELS-1:0]             ch_dump,
  input  logic [NUM_CHANNELS*6*ACC_WIDTH-1:0] ch_acc,
`ifdef NAMURU_DUMP_TIMESTAMP_EN
  input  logic [23:0]                         accum_count,
`endif
  input  logic                                rd_en,
  input  logic [7:0]                          rd_addr,
  output logic [31:0]                         rd_data,
  output logic                                rd_valid,
  input  logic                                clr_we,
  input  logic [NUM_CHANNELS-1:0]             clr_data,
  output logic [NUM_CHANNELS-1:0]             new_data,
  output logic [NUM_CHANNELS-1:0]             overrun,
  output logic                                irq
);

  logic [ACC_WIDTH-1:0]    shadow_q [NUM_CHANNELS][6];
  logic [ACC_WIDTH-1:0]    shadow_d [NUM_CHANNELS][6];
  logic [NUM_CHANNELS-1:0] new_data_q, new_data_d;
  logic [NUM_CHANNELS-1:0] overrun_q, overrun_d;
  logic                    irq_q, irq_d;
  logic [31:0]             rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [31:0]             rd_word;
  logic                    clr_k;
`ifdef NAMURU_DUMP_TIMESTAMP_EN
  logic [23:0]             ts_q [NUM_CHANNELS];
  logic [23:0]             ts_d [NUM_CHANNELS];
`endif

  always_comb begin
    shadow_d   = shadow_q;
    new_data_d = new_data_q;
    overrun_d  = overrun_q;
    clr_k      = 1'b0;
`ifdef NAMURU_DUMP_TIMESTAMP_EN
    ts_d       = ts_q;
`endif
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      clr_k = clr_we & clr_data[k];
      // A dump racing a clear keeps the overrun bit as it was and re-arms new_data.
      if (ch_dump[k]) begin
        for (int unsigned j = 0; j < 6; j++)
          shadow_d[k][j] = ch_acc[(k*6+j)*ACC_WIDTH +: ACC_WIDTH];
`ifdef NAMURU_DUMP_TIMESTAMP_EN
        ts_d[k] = accum_count;
`endif
        new_data_d[k] = 1'b1;
        overrun_d[k]  = overrun_q[k] | (new_data_q[k] & ~clr_k);
      end else if (clr_k) begin
        new_data_d[k] = 1'b0;
        overrun_d[k]  = 1'b0;
      end
    end
    irq_d = (accum_int & (|new_data_q)) | (irq_q & ~clr_we);
  end

  always_comb begin
    rd_word = '0;
    if (rd_addr == 8'h00) begin
      rd_word[NUM_CHANNELS-1:0]     = new_data_q;
      rd_word[16 +: NUM_CHANNELS]   = overrun_q;
    end
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      for (int unsigned j = 0; j < 6; j++)
        if (rd_addr == 8'(1 + 6*k + j))
          rd_word = 32'($signed(shadow_q[k][j]));
`ifdef NAMURU_DUMP_TIMESTAMP_EN
      if (rd_addr == 8'(8'h80 + k))
        rd_word = 32'(ts_q[k]);
`endif
    end
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
        for (int unsigned j = 0; j < 6; j++)
          shadow_q[k][j] <= '0;
`ifdef NAMURU_DUMP_TIMESTAMP_EN
        ts_q[k] <= '0;
`endif
      end
      new_data_q <= '0;
      overrun_q  <= '0;
      irq_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
`ifdef NAMURU_DUMP_TIMESTAMP_EN
      ts_q       <= ts_d;
`endif
      new_data_q <= new_data_d;
      overrun_q  <= overrun_d;
      irq_q      <= irq_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign new_data = new_data_q;
  assign overrun  = overrun_q;
  assign irq      = irq_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_namuru_dump_collector.sv
// Randomized bench for namuru_dump_collector against an array-based behavioural model.
module tb_namuru_dump_collector;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = N*6*W;

  logic          clk = 1'b0;
  logic          rstn;
  logic          accum_int;
  logic [N-1:0]  ch_dump;
  logic [AW-1:0] ch_acc;
`ifdef NAMURU_DUMP_TIMESTAMP_EN
  logic [23:0]   accum_count;
`endif
  logic          rd_en;
  logic [7:0]    rd_addr;
  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          clr_we;
  logic [N-1:0]  clr_data;
  logic [N-1:0]  new_data;
  logic [N-1:0]  overrun;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]  m_sh [N][6];
  logic [23:0]   m_ts [N];
  logic [N-1:0]  m_nd, m_ov;
  logic          m_irq, m_rv;
  logic [31:0]   m_rd;

  namuru_dump_collector #(.NUM_CHANNELS(N), .ACC_WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .accum_int(accum_int), .ch_dump(ch_dump), .ch_acc(ch_acc),
`ifdef NAMURU_DUMP_TIMESTAMP_EN
    .accum_count(accum_count),
`endif
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_we(clr_we), .clr_data(clr_data), .new_data(new_data), .overrun(overrun), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int idx, k, j, v;
    if (a == 8'h00) return (32'(m_ov) << 16) | 32'(m_nd);
    if (a >= 8'd1 && int'(a) <= 6*N) begin
      idx = int'(a) - 1;
      k = idx / 6;
      j = idx % 6;
      v = int'(m_sh[k][j]);
      if (m_sh[k][j][W-1]) v = v - (1 << W);
      return 32'(v);
    end
`ifdef NAMURU_DUMP_TIMESTAMP_EN
    if (a >= 8'h80 && int'(a) < 8'h80 + N) return 32'(m_ts[int'(a) - 8'h80]);
`endif
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < 6; j++) m_sh[k][j] = '0;
      m_ts[k] = '0;
    end
    m_nd = '0; m_ov = '0; m_irq = 1'b0; m_rv = 1'b0; m_rd = '0;
  endtask

  task automatic idle();
    accum_int = 1'b0; ch_dump = '0; ch_acc = '0; rd_en = 1'b0; rd_addr = '0;
    clr_we = 1'b0; clr_data = '0;
`ifdef NAMURU_DUMP_TIMESTAMP_EN
    accum_count = '0;
`endif
  endtask

  // Advance the model from the current inputs, clock the DUT, compare just after the edge.
  task automatic tick();
    logic [N-1:0] nd_old;
    logic c;
    nd_old = m_nd;
    if (!rstn) model_reset();
    else begin
      m_rv = rd_en;
      m_rd = rd_en ? model_read(rd_addr) : 32'h0;
      for (int k = 0; k < N; k++) begin
        c = clr_we && clr_data[k];
        if (ch_dump[k]) begin
          for (int j = 0; j < 6; j++) m_sh[k][j] = ch_acc[(k*6+j)*W +: W];
`ifdef NAMURU_DUMP_TIMESTAMP_EN
          m_ts[k] = accum_count;
`endif
          if (nd_old[k] && !c) m_ov[k] = 1'b1;
          m_nd[k] = 1'b1;
        end else if (c) begin
          m_nd[k] = 1'b0;
          m_ov[k] = 1'b0;
        end
      end
      if (accum_int && nd_old != 0) m_irq = 1'b1;
      else if (clr_we) m_irq = 1'b0;
    end
    @(posedge clk);
    #1;
    check("new_data", 32'(new_data), 32'(m_nd));
    check("overrun",  32'(overrun),  32'(m_ov));
    check("irq",      32'(irq),      32'(m_irq));
    check("rd_valid", 32'(rd_valid), 32'(m_rv));
    if (m_rv || !rstn) check("rd_data", rd_data, m_rd);
  endtask

  task automatic randomize_inputs();
    int sel;
    accum_int = ($urandom_range(0, 3) == 0);
    ch_dump   = N'($urandom) & N'($urandom);
    for (int b = 0; b < AW; b++) ch_acc[b] = 1'($urandom);
    rd_en     = 1'($urandom);
    sel       = $urandom_range(0, 9);
    if (sel < 6)      rd_addr = 8'($urandom_range(0, 6*N + 1));
    else if (sel < 8) rd_addr = 8'($urandom_range(8'h80, 8'h80 + N));
    else              rd_addr = 8'($urandom);
    clr_we    = ($urandom_range(0, 3) == 0);
    clr_data  = N'($urandom);
`ifdef NAMURU_DUMP_TIMESTAMP_EN
    accum_count = 24'($urandom);
`endif
  endtask

  initial begin
    idle();
    rstn = 1'b0;
    model_reset();

    // Reset holds everything at zero even with busy inputs
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      tick();
    end
    check("rst_irq", 32'(irq), 32'h0);
    rstn = 1'b1;
    idle();
    rd_en = 1'b1; rd_addr = 8'h00;
    tick();
    check("rst_status_read", rd_data, 32'h0);

    // Sign-extended read of ch2 i_early
    idle();
    ch_dump = 4'b0100;
    ch_acc[(2*6+0)*W +: W] = 16'hFFFE;
    tick();
    check("t2_new_data", 32'(new_data), 32'h4);
    idle();
    rd_en = 1'b1; rd_addr = 8'h0D;
    tick();
    check("t2_rd_data", rd_data, 32'hFFFF_FFFE);
    check("t2_rd_valid", 32'(rd_valid), 32'h1);
    idle();
    tick();
    check("t2_rd_valid_drop", 32'(rd_valid), 32'h0);

    // Overrun on ch1
    idle(); clr_we = 1'b1; clr_data = '1; tick();
    idle(); ch_dump = 4'b0010; tick();
    idle(); ch_dump = 4'b0010; tick();
    check("t3_overrun", 32'(overrun), 32'h2);
    idle(); rd_en = 1'b1; rd_addr = 8'h00; tick();
    check("t3_status", rd_data, 32'h0002_0002);
    idle(); clr_we = 1'b1; clr_data = 4'b0010; tick();
    check("t3_clr", 32'({overrun, new_data}), 32'h0);

    // Dump racing clear on ch0
    idle(); ch_dump = 4'b0001; clr_we = 1'b1; clr_data = 4'b0001; tick();
    check("t4_nd0", 32'(new_data[0]), 32'h1);
    check("t4_ov0", 32'(overrun[0]), 32'h0);

    // irq set/clear precedence
    idle(); accum_int = 1'b1; tick();
    check("t5_irq_set", 32'(irq), 32'h1);
    idle(); accum_int = 1'b1; clr_we = 1'b1; clr_data = '0; tick();
    check("t5_irq_set_wins", 32'(irq), 32'h1);
    idle(); clr_we = 1'b1; clr_data = '0; tick();
    check("t5_irq_clr", 32'(irq), 32'h0);

    // Timestamp on ch3
    idle(); ch_dump = 4'b1000;
`ifdef NAMURU_DUMP_TIMESTAMP_EN
    accum_count = 24'h00ABCD;
`endif
    tick();
    idle(); rd_en = 1'b1; rd_addr = 8'h83; tick();
`ifdef NAMURU_DUMP_TIMESTAMP_EN
    check("t6_ts", rd_data, 32'h0000_ABCD);
`else
    check("t6_ts", rd_data, 32'h0);
`endif

    // Random traffic with occasional mid-operation reset
    for (int i = 0; i < 2000; i++) begin
      randomize_inputs();
      rstn = ($urandom_range(0, 99) != 0);
      tick();
    end
    rstn = 1'b1;
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
